// File: rtl/dispense_sequencer.sv
// Purpose: turns a Pi dispense request (level + amount code) into an exact,
//          counted burst of stepper pulses with DC-motor enable and a level
//          completion handshake.
// Latency: step_o rises 3 clocks after the first edge that samples candy_req=1;
//          a dispense lasts 2*HALF_PERIOD*steps clocks from first step to DONE.
// Backpressure: new requests are ignored while busy; DONE holds handshake until
//          the Pi drops candy_req.
// Ports: clk/rst (sync, active-high); candy_req, amount[1:0], dir_sel (async
//        Pi inputs); step_o, dir_o, dc_en (motor drive); busy, handshake, err,
//        step_count[15:0] (status).
module dispense_sequencer #(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned STEPS_SMALL = 200,
    parameter int unsigned STEPS_MED   = 400,
    parameter int unsigned STEPS_LARGE = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        candy_req,
    input  logic [1:0]  amount,
    input  logic        dir_sel,
    output logic        step_o,
    output logic        dir_o,
    output logic        dc_en,
    output logic        busy,
    output logic        handshake,
    output logic        err,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP_HI = 2'd1,
        STEP_LO = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] HP_M1   = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] T_SMALL = 16'(STEPS_SMALL);
    localparam logic [15:0] T_MED   = 16'(STEPS_MED);
    localparam logic [15:0] T_LARGE = 16'(STEPS_LARGE);

    state_t      state;
    logic        req_s1, req_s2, req_d, req_rise;
    logic [1:0]  amt_s1, amt_s2;
    logic        dir_s1, dir_s2;
    logic [15:0] half_cnt;
    logic [15:0] target;
    logic [15:0] sel_target;

    // Two-flop synchronisers plus a registered rising-edge detect. The extra
    // register on req_rise is what places the first step_o rise at edge k+3.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1   <= 1'b0;
            req_s2   <= 1'b0;
            req_d    <= 1'b0;
            req_rise <= 1'b0;
            amt_s1   <= 2'b00;
            amt_s2   <= 2'b00;
            dir_s1   <= 1'b0;
            dir_s2   <= 1'b0;
        end else begin
            req_s1   <= candy_req;
            req_s2   <= req_s1;
            req_d    <= req_s2;
            req_rise <= req_s2 & ~req_d;
            amt_s1   <= amount;
            amt_s2   <= amt_s1;
            dir_s1   <= dir_sel;
            dir_s2   <= dir_s1;
        end
    end

    always_comb begin
        sel_target = T_SMALL;
        case (amt_s2)
            2'b00:   sel_target = T_SMALL;
            2'b01:   sel_target = T_MED;
            2'b10:   sel_target = T_LARGE;
            default: sel_target = T_SMALL;
        endcase
    end

    // All outputs are registered and updated alongside the state transition,
    // so each output changes on the same edge the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            half_cnt   <= 16'd0;
            target     <= 16'd0;
            step_o     <= 1'b0;
            dir_o      <= 1'b0;
            dc_en      <= 1'b0;
            busy       <= 1'b0;
            handshake  <= 1'b0;
            err        <= 1'b0;
            step_count <= 16'd0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_rise) begin
                        if (amt_s2 == 2'b11) begin
                            err <= 1'b1;
                        end else begin
                            target     <= sel_target;
                            dir_o      <= dir_s2;
                            step_count <= 16'd0;
                            half_cnt   <= HP_M1;
                            step_o     <= 1'b1;
                            dc_en      <= 1'b1;
                            busy       <= 1'b1;
                            state      <= STEP_HI;
                        end
                    end
                end
                STEP_HI: begin
                    if (half_cnt == 16'd0) begin
                        half_cnt   <= HP_M1;
                        step_count <= step_count + 16'd1;
                        step_o     <= 1'b0;
                        state      <= STEP_LO;
                    end else begin
                        half_cnt <= half_cnt - 16'd1;
                    end
                end
                STEP_LO: begin
                    if (half_cnt == 16'd0) begin
                        if (step_count == target) begin
                            dc_en     <= 1'b0;
                            handshake <= 1'b1;
                            state     <= DONE;
                        end else begin
                            half_cnt <= HP_M1;
                            step_o   <= 1'b1;
                            state    <= STEP_HI;
                        end
                    end else begin
                        half_cnt <= half_cnt - 16'd1;
                    end
                end
                DONE: begin
                    // Hold completion until the Pi releases its request; if it
                    // already has, DONE lasts a single cycle.
                    if (!req_s2) begin
                        handshake <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
